hilo_div_ctrl: RTL and testbench

- EX-stage sequencer for DIV/DIVU. It sits between the EX decode and the 32-cycle radix-2 divider.
- Captures the operands, issues a one-cycle start to the divider, stalls EX until the divider finishes, then writes {remainder, quotient} into the HI/LO registers it owns.
- Also accepts MTHI/MTLO/MULT-style HI/LO writes from later stages.
- Handles pipeline flush mid-division by draining the divider and discarding its result.

---
 rtl/hilo_div_ctrl.sv | 140 ++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// EX-stage sequencer for DIV/DIVU. Captures operands, pulses the divider
// start, stalls EX while the divider iterates, then commits {rem, quo} into
// the HI/LO pair it owns. Also services HI/LO writes from the non-divide
// path and drains a killed divide so its result never reaches HI/LO.
module hilo_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_div_req,
  input  logic                  ex_div_sign,
  input  logic [DATA_W-1:0]     ex_a,
  input  logic [DATA_W-1:0]     ex_b,
  input  logic                  ex_hold,
  input  logic                  flush,
  input  logic [1:0]            hilo_we,
  input  logic [2*DATA_W-1:0]   hilo_wdata,
  output logic                  div_start,
  output logic                  div_sign,
  output logic [DATA_W-1:0]     div_a,
  output logic [DATA_W-1:0]     div_b,
  input  logic                  div_busy,
  input  logic [2*DATA_W-1:0]   div_result,
  output logic                  stall_ex,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic                start_q, start_d;
  logic                sign_q, sign_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                armed_q, armed_d;
  logic                div_wr;

  // Next-state, operand capture, HI/LO write arbitration and EX stall.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    sign_d   = sign_q;
    a_d      = a_q;
    b_d      = b_q;
    armed_d  = armed_q;
    div_wr   = 1'b0;
    stall_ex = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_ex = ex_div_req & ~flush;
        if (ex_div_req && !flush) begin
          a_d     = ex_a;
          b_d     = ex_b;
          sign_d  = ex_div_sign;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        stall_ex = 1'b1;
        // The divider accepts the start at this edge regardless of flush,
        // so a killed op must first see busy rise before it can drain.
        armed_d  = 1'b0;
        state_d  = flush ? S_DRAIN : S_BUSY;
      end
      S_BUSY: begin
        stall_ex = 1'b1;
        if (flush) begin
          armed_d = 1'b1;
          state_d = S_DRAIN;
        end else if (!div_busy) begin
          div_wr  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Same instruction still sits in EX; its request is not a new divide.
        if (flush || !ex_hold) state_d = S_IDLE;
      end
      S_DRAIN: begin
        stall_ex = ex_div_req;
        armed_d  = armed_q | div_busy;
        if (armed_q && !div_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Divide commit is the younger instruction, so it wins over hilo_we.
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_wr) begin
      hi_d = div_result[2*DATA_W-1:DATA_W];
      lo_d = div_result[DATA_W-1:0];
    end else begin
      if (hilo_we[1]) hi_d = hilo_wdata[2*DATA_W-1:DATA_W];
      if (hilo_we[0]) lo_d = hilo_wdata[DATA_W-1:0];
    end
  end

  // State and output registers; the divider shares this reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      sign_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      sign_q  <= sign_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      armed_q <= armed_d;
    end
  end

  assign div_start = start_q;
  assign div_sign  = sign_q;
  assign div_a     = a_q;
  assign div_b     = b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl with a behavioural 32-cycle divider attached.
module tb_hilo_div_ctrl;

  logic        clk, rst;
  logic        ex_div_req, ex_div_sign, ex_hold, flush;
  logic [31:0] ex_a, ex_b;
  logic [1:0]  hilo_we;
  logic [63:0] hilo_wdata;
  logic        div_start, div_sign, div_busy, stall_ex;
  logic [31:0] div_a, div_b, hi, lo;
  logic [63:0] div_result;

  int total = 0;
  int bad   = 0;

  hilo_div_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_div_req(ex_div_req), .ex_div_sign(ex_div_sign),
    .ex_a(ex_a), .ex_b(ex_b), .ex_hold(ex_hold), .flush(flush),
    .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
    .div_start(div_start), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_result(div_result),
    .stall_ex(stall_ex), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: busy for 32 cycles after the start edge, result valid
  // only once idle, sign correction applied live from div_sign.
  logic [5:0]         cnt;
  logic [31:0]        ra, rb;
  logic signed [31:0] sq, sr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 6'd0; ra <= 32'd0; rb <= 32'd0;
    end else if (div_start) begin
      cnt <= 6'd32; ra <= div_a; rb <= div_b;
    end else if (cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
    end
  end
  assign div_busy = (cnt != 6'd0);
  always_comb begin
    sq = '0;
    sr = '0;
    div_result = 64'hDEAD_BEEF_DEAD_BEEF;
    if (!div_busy) begin
      if (rb == 32'd0) div_result = {ra, 32'hFFFF_FFFF};
      else if (div_sign) begin
        sq = $signed(ra) / $signed(rb);
        sr = $signed(ra) % $signed(rb);
        div_result = {sr, sq};
      end else div_result = {ra % rb, ra / rb};
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Full no-hazard divide with cycle-exact latency checks.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
    ex_div_req = 1'b1; ex_div_sign = sg; ex_a = a; ex_b = b;
    #1;
    chk("c0_stall", stall_ex, 1);
    chk("c0_start", div_start, 0);
    step();
    for (int c = 1; c <= 34; c++) begin
      ex_div_sign = ~sg; ex_a = ~a; ex_b = ~b;   // operands must stay captured
      #1;
      chk("busy_stall", stall_ex, 1);
      chk("start_pulse", div_start, (c == 1));
      chk("sign_hold", div_sign, sg);
      chk("a_hold", div_a, a);
      chk("b_hold", div_b, b);
      step();
    end
    chk("c35_stall", stall_ex, 0);
    chk("hi", hi, ehi);
    chk("lo", lo, elo);
    ex_div_req = 1'b0;
    step();
    chk("c36_stall", stall_ex, 0);
    chk("c36_start", div_start, 0);
  endtask

  // Kill a divide at flush_cyc, then request a new one right after; it must
  // not start until the divider has drained (cycle 36).
  task automatic drain_seq(input int flush_cyc, input logic [31:0] na, input logic [31:0] nb,
                           input logic [31:0] ehi, input logic [31:0] elo,
                           input logic [31:0] keep_hi, input logic [31:0] keep_lo);
    int st_cyc;
    int cyc;
    st_cyc = -1;
    ex_div_req = 1'b1; ex_div_sign = 1'b0; ex_a = 32'd9; ex_b = 32'd4;
    for (cyc = 0; cyc < flush_cyc; cyc++) step();
    flush = 1'b1;
    step();
    flush = 1'b0; ex_a = na; ex_b = nb;
    cyc = flush_cyc + 1;
    while (st_cyc < 0 && cyc < 80) begin
      #1;
      if (div_start) st_cyc = cyc;
      else begin
        chk("drain_stall", stall_ex, 1);
        chk("drain_hi", hi, keep_hi);
        chk("drain_lo", lo, keep_lo);
      end
      if (st_cyc < 0) begin step(); cyc++; end
    end
    chk("drain_start_cycle", st_cyc, 36);
    for (int i = 0; i < 34; i++) step();
    chk("post_drain_stall", stall_ex, 0);
    chk("post_drain_hi", hi, ehi);
    chk("post_drain_lo", lo, elo);
    ex_div_req = 1'b0;
    step();
  endtask

  typedef struct {
    logic        sg;
    logic [31:0] a, b, ehi, elo;
  } vec_t;
  vec_t tbl[7];

  int starts;

  initial begin
    tbl[0] = '{1'b0, 32'd100,        32'd7,          32'h0000_0002, 32'h0000_000E};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[2] = '{1'b0, 32'd9,          32'd4,          32'h0000_0001, 32'h0000_0002};
    tbl[3] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'h0000_000E};
    tbl[4] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'h0000_0002, 32'hFFFF_FFF2};
    tbl[5] = '{1'b0, 32'hFFFF_FFFF,  32'd10,         32'h0000_0005, 32'h1999_9999};
    tbl[6] = '{1'b0, 32'd5,          32'd0,          32'h0000_0005, 32'hFFFF_FFFF};

    rst = 1'b1; ex_div_req = 1'b0; ex_div_sign = 1'b0; ex_a = '0; ex_b = '0;
    ex_hold = 1'b0; flush = 1'b0; hilo_we = 2'b00; hilo_wdata = '0;
    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", stall_ex, 0);
    chk("rst_start", div_start, 0);
    chk("rst_sign", div_sign, 0);
    chk("rst_a", div_a, 0);
    chk("rst_b", div_b, 0);
    step();
    rst = 1'b0;
    step();

    foreach (tbl[i]) run_div(tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo);

    // Preload, then kill a divide mid-iteration.
    hilo_we = 2'b11; hilo_wdata = 64'h1111_1111_2222_2222;
    step();
    hilo_we = 2'b00;
    chk("pre_hi", hi, 32'h1111_1111);
    chk("pre_lo", lo, 32'h2222_2222);
    drain_seq(10, 32'd8, 32'd2, 32'd0, 32'd4, 32'h1111_1111, 32'h2222_2222);

    // Kill in the START cycle: divider already accepted the start.
    drain_seq(1, 32'd100, 32'd7, 32'd2, 32'd14, 32'd0, 32'd4);

    // Downstream hold after completion: stay in DONE, no second start.
    starts = 0;
    ex_div_req = 1'b1; ex_div_sign = 1'b0; ex_a = 32'd9; ex_b = 32'd4;
    for (int c = 0; c < 46; c++) begin
      ex_hold = (c >= 35 && c <= 39);
      if (c == 41) ex_div_req = 1'b0;
      #1;
      if (div_start) starts++;
      if (c >= 35 && c <= 40) chk("hold_stall", stall_ex, 0);
      step();
    end
    ex_hold = 1'b0;
    chk("hold_starts", starts, 1);
    chk("hold_hi", hi, 32'd1);
    chk("hold_lo", lo, 32'd2);

    // Same-cycle hilo_we vs. divide commit, then a lone LO write.
    ex_div_req = 1'b1; ex_a = 32'd9; ex_b = 32'd4;
    for (int c = 0; c < 34; c++) step();
    hilo_we = 2'b11; hilo_wdata = 64'hAAAA_AAAA_BBBB_BBBB;
    step();
    hilo_we = 2'b01; hilo_wdata = 64'h0000_0000_CCCC_CCCC;
    #1;
    chk("conf_hi", hi, 32'd1);
    chk("conf_lo", lo, 32'd2);
    step();
    hilo_we = 2'b00; ex_div_req = 1'b0;
    chk("lone_lo", lo, 32'hCCCC_CCCC);
    chk("lone_hi", hi, 32'd1);
    step();

    // Reset in the middle of a divide.
    ex_div_req = 1'b1; ex_a = 32'd100; ex_b = 32'd7;
    for (int c = 0; c < 20; c++) step();
    rst = 1'b1; ex_div_req = 1'b0;
    #1;
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    chk("mid_rst_stall", stall_ex, 0);
    chk("mid_rst_start", div_start, 0);
    step();
    rst = 1'b0;
    step();
    run_div(1'b0, 32'd7, 32'd7, 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
